// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF/MEM request ports, the RAM port and the completion/stall
// outputs of the memory port arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 8
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       ram_q;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic              ram_wren;
  logic              if_valid;
  logic [31:0]       if_rdata;
  logic              mem_valid;
  logic [31:0]       mem_rdata;
  logic              stall_if;
  logic              stall_mem;
  logic              busy;

  // Pipeline / RAM side: issues requests and returns RAM read data.
  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_q,
    input  ram_addr, ram_wdata, ram_wren, if_valid, if_rdata,
           mem_valid, mem_rdata, stall_if, stall_mem, busy
  );

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_q,
    output ram_addr, ram_wdata, ram_wren, if_valid, if_rdata,
           mem_valid, mem_rdata, stall_if, stall_mem, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between instruction fetch and the MEM stage.
// One transaction at a time: IDLE grants, WAIT counts the RAM latency
// (or one cycle for a store), RESP pulses the matching valid.
module mem_port_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int RAM_LAT = 1
) (
  input logic            clock,
  input logic            reset,
  mem_port_arbiter_if.slave bus
);

  if (RAM_LAT < 1 || RAM_LAT > 4) begin : g_bad_lat
    $error("mem_port_arbiter: RAM_LAT must be in 1..4");
  end

  localparam logic [2:0] LAT_CNT = 3'(RAM_LAT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_r,     state_s;
  logic [2:0]        cnt_r,       cnt_s;
  logic              last_data_r, last_data_s;   // 1: data port won the last grant
  logic              sel_data_r,  sel_data_s;    // current transaction belongs to data port
  logic              sel_store_r, sel_store_s;   // current transaction is a store
  logic [ADDR_W-1:0] ram_addr_r,  ram_addr_s;
  logic [31:0]       ram_wdata_r, ram_wdata_s;
  logic              ram_wren_r,  ram_wren_s;
  logic [31:0]       if_rdata_r,  if_rdata_s;
  logic [31:0]       mem_rdata_r, mem_rdata_s;
  logic              if_valid_r,  if_valid_s;
  logic              mem_valid_r, mem_valid_s;

  // Next-state and next-output logic: grant in IDLE, count in WAIT, release in RESP.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    last_data_s = last_data_r;
    sel_data_s  = sel_data_r;
    sel_store_s = sel_store_r;
    ram_addr_s  = ram_addr_r;
    ram_wdata_s = ram_wdata_r;
    ram_wren_s  = 1'b0;
    if_rdata_s  = if_rdata_r;
    mem_rdata_s = mem_rdata_r;
    if_valid_s  = 1'b0;
    mem_valid_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.mem_req && (!bus.if_req || !last_data_r)) begin
          state_s     = WAIT;
          last_data_s = 1'b1;
          sel_data_s  = 1'b1;
          sel_store_s = bus.mem_we;
          ram_addr_s  = bus.mem_addr;
          ram_wdata_s = bus.mem_wdata;
          ram_wren_s  = bus.mem_we;
          cnt_s       = bus.mem_we ? 3'd1 : LAT_CNT;
        end else if (bus.if_req) begin
          state_s     = WAIT;
          last_data_s = 1'b0;
          sel_data_s  = 1'b0;
          sel_store_s = 1'b0;
          ram_addr_s  = bus.if_addr;
          cnt_s       = LAT_CNT;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        cnt_s = cnt_r - 3'd1;
        if (cnt_r == 3'd1) begin
          state_s = RESP;
          if (sel_data_r) begin
            mem_valid_s = 1'b1;
            if (!sel_store_r) begin
              mem_rdata_s = bus.ram_q;
            end else begin
              mem_rdata_s = mem_rdata_r;
            end
          end else begin
            if_valid_s = 1'b1;
            if_rdata_s = bus.ram_q;
          end
        end else begin
          state_s = WAIT;
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers; synchronous reset overrides any transaction.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= 3'd0;
      last_data_r <= 1'b0;
      sel_data_r  <= 1'b0;
      sel_store_r <= 1'b0;
      ram_addr_r  <= '0;
      ram_wdata_r <= 32'd0;
      ram_wren_r  <= 1'b0;
      if_rdata_r  <= 32'd0;
      mem_rdata_r <= 32'd0;
      if_valid_r  <= 1'b0;
      mem_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      last_data_r <= last_data_s;
      sel_data_r  <= sel_data_s;
      sel_store_r <= sel_store_s;
      ram_addr_r  <= ram_addr_s;
      ram_wdata_r <= ram_wdata_s;
      ram_wren_r  <= ram_wren_s;
      if_rdata_r  <= if_rdata_s;
      mem_rdata_r <= mem_rdata_s;
      if_valid_r  <= if_valid_s;
      mem_valid_r <= mem_valid_s;
    end
  end

  assign bus.ram_addr  = ram_addr_r;
  assign bus.ram_wdata = ram_wdata_r;
  assign bus.ram_wren  = ram_wren_r;
  assign bus.if_rdata  = if_rdata_r;
  assign bus.mem_rdata = mem_rdata_r;
  assign bus.if_valid  = if_valid_r;
  assign bus.mem_valid = mem_valid_r;
  assign bus.busy      = (state_r != IDLE);
  assign bus.stall_if  = bus.if_req  & ~if_valid_r;
  assign bus.stall_mem = bus.mem_req & ~mem_valid_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: two arbiters (RAM_LAT 1 and 3) each driven by its own
// directed + random request stream and checked cycle by cycle against a
// transaction-level model (grant alternation, latency, reference memory).
module tb_mem_port_arbiter;

  logic clock;
  int   total = 0;
  int   bad   = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [7:0] a);
    return {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int LAT = (g == 0) ? 1 : 3;
    localparam int NTX = 80;

    mem_port_arbiter_if #(.ADDR_W(8)) bus ();
    logic        rst;
    logic        mem_clr;
    logic [31:0] ram_mem [0:255];
    logic [255:0] ram_wr;
    logic [31:0] qpipe [0:3];
    logic [31:0] rd_now;
    bit          done = 1'b0;

    mem_port_arbiter #(.ADDR_W(8), .RAM_LAT(LAT)) dut (
      .clock (clock),
      .reset (rst),
      .bus   (bus)
    );

    // RAM write port; unwritten words read back a fixed address pattern
    always @(posedge clock) begin
      if (mem_clr) begin
        ram_wr <= '0;
      end else if (bus.ram_wren) begin
        ram_mem[bus.ram_addr] <= bus.ram_wdata;
        ram_wr[bus.ram_addr]  <= 1'b1;
      end
    end

    assign rd_now = ram_wr[bus.ram_addr] ? ram_mem[bus.ram_addr] : dflt(bus.ram_addr);

    // RAM read pipeline so that ram_q is valid LAT edges after the address edge
    always @(posedge clock) begin
      qpipe[0] <= rd_now;
      for (int i = 1; i < 4; i++) qpipe[i] <= qpipe[i-1];
    end

    if (LAT == 1) begin : g_q
      assign bus.ram_q = rd_now;
    end else begin : g_q
      assign bus.ram_q = qpipe[LAT-2];
    end

    // reference model state
    logic [31:0] ref_mem [0:255];
    bit          last_data;
    bit          p_if, p_mem, p_we;
    logic [7:0]  a_if, a_mem;
    logic [31:0] wd;
    logic [7:0]  e_addr;
    logic [31:0] e_wdata, e_ifd, e_memd;
    bit          win_d, is_st, do_rst, rst_at, in_reset;
    bit          exp_busy, exp_ifv, exp_memv, exp_wren;
    int          lat_l, ncyc, kind;
    string       pfx;
    int          d_kind [13];
    logic [7:0]  d_addr [13];
    logic [31:0] d_data [13];
    bit          d_rst  [13];

    initial begin
      pfx = (LAT == 1) ? "L1 " : "L3 ";
      // kinds: 0 fetch, 1 load, 2 store, 3 both pending, 4 nothing new
      d_kind = '{3, 3, 3, 4, 2, 1, 2, 2, 0, 1, 1, 2, 1};
      d_addr = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h10, 8'h22, 8'h04,
                 8'h04, 8'h22, 8'h22, 8'h30, 8'h30};
      d_data = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hDEADBEEF, 32'd0, 32'h12345678,
                 32'h20080005, 32'd0, 32'd0, 32'd0, 32'hCAFEF00D, 32'd0};
      d_rst  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                 1'b1, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 256; i++) ref_mem[i] = dflt(8'(i));
      last_data = 1'b0;
      e_addr = 8'd0; e_wdata = 32'd0; e_ifd = 32'd0; e_memd = 32'd0;
      // both requesters already asking while reset is applied
      p_if = 1'b1; a_if = 8'($urandom);
      p_mem = 1'b1; p_we = 1'b0; a_mem = 8'($urandom); wd = $urandom;
      bus.if_req = p_if; bus.if_addr = a_if;
      bus.mem_req = p_mem; bus.mem_we = p_we; bus.mem_addr = a_mem; bus.mem_wdata = wd;
      rst = 1'b1; mem_clr = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      chk({pfx, "rst_busy"},   32'(bus.busy), 32'd0);
      chk({pfx, "rst_wren"},   32'(bus.ram_wren), 32'd0);
      chk({pfx, "rst_addr"},   32'(bus.ram_addr), 32'd0);
      chk({pfx, "rst_wdata"},  bus.ram_wdata, 32'd0);
      chk({pfx, "rst_ifd"},    bus.if_rdata, 32'd0);
      chk({pfx, "rst_memd"},   bus.mem_rdata, 32'd0);
      chk({pfx, "rst_valids"}, {30'd0, bus.if_valid, bus.mem_valid}, 32'd0);
      chk({pfx, "rst_stall"},  {30'd0, bus.stall_if, bus.stall_mem}, 32'd3);
      rst = 1'b0; mem_clr = 1'b0;

      for (int n = 0; n < NTX; n++) begin
        do_rst = 1'b0;
        if (n < 13) begin
          kind = d_kind[n];
          do_rst = d_rst[n];
          case (kind)
            0: begin p_if = 1'b1; a_if = d_addr[n]; end
            1: begin p_mem = 1'b1; p_we = 1'b0; a_mem = d_addr[n]; wd = $urandom; end
            2: begin p_mem = 1'b1; p_we = 1'b1; a_mem = d_addr[n]; wd = d_data[n]; end
            3: begin
              if (!p_if)  begin p_if = 1'b1; a_if = 8'($urandom); end
              if (!p_mem) begin p_mem = 1'b1; p_we = 1'b0; a_mem = 8'($urandom); wd = $urandom; end
            end
            default: begin end
          endcase
        end else begin
          if (!p_if && ($urandom_range(0, 1) == 1)) begin p_if = 1'b1; a_if = 8'($urandom); end
          if (!p_mem && ($urandom_range(0, 1) == 1)) begin
            p_mem = 1'b1; p_we = 1'($urandom); a_mem = 8'($urandom); wd = $urandom;
          end
          do_rst = ($urandom_range(0, 15) == 0);
        end
        bus.if_req = p_if; bus.if_addr = a_if;
        bus.mem_req = p_mem; bus.mem_we = p_we; bus.mem_addr = a_mem; bus.mem_wdata = wd;

        // transaction-level prediction for this slot
        win_d = p_mem && (!p_if || !last_data);
        is_st = win_d && p_we;
        lat_l = (!p_if && !p_mem) ? 0 : (is_st ? 2 : LAT + 1);
        ncyc  = lat_l + 1;
        rst_at = do_rst && (lat_l > 0);
        in_reset = 1'b0;
        if (lat_l > 0) begin
          last_data = win_d;
          e_addr = win_d ? a_mem : a_if;
          if (win_d) e_wdata = wd;
          if (is_st) ref_mem[a_mem] = wd;
        end

        for (int k = 1; k <= ncyc; k++) begin
          @(posedge clock);
          #1;
          if (in_reset) begin
            exp_busy = 1'b0; exp_ifv = 1'b0; exp_memv = 1'b0; exp_wren = 1'b0;
          end else begin
            exp_busy = (k <= lat_l);
            exp_ifv  = (lat_l > 0) && (k == lat_l) && !win_d;
            exp_memv = (lat_l > 0) && (k == lat_l) && win_d;
            exp_wren = (k == 1) && is_st;
            if ((lat_l > 0) && (k == lat_l) && !is_st) begin
              if (win_d) e_memd = ref_mem[e_addr];
              else       e_ifd  = ref_mem[e_addr];
            end
          end
          chk({pfx, "busy"},      32'(bus.busy), 32'(exp_busy));
          chk({pfx, "if_valid"},  32'(bus.if_valid), 32'(exp_ifv));
          chk({pfx, "mem_valid"}, 32'(bus.mem_valid), 32'(exp_memv));
          chk({pfx, "ram_wren"},  32'(bus.ram_wren), 32'(exp_wren));
          chk({pfx, "ram_addr"},  32'(bus.ram_addr), 32'(e_addr));
          chk({pfx, "ram_wdata"}, bus.ram_wdata, e_wdata);
          chk({pfx, "if_rdata"},  bus.if_rdata, e_ifd);
          chk({pfx, "mem_rdata"}, bus.mem_rdata, e_memd);
          chk({pfx, "stall_if"},  32'(bus.stall_if), 32'(bus.if_req & ~exp_ifv));
          chk({pfx, "stall_mem"}, 32'(bus.stall_mem), 32'(bus.mem_req & ~exp_memv));

          // inputs for the next edge
          if (in_reset) begin
            rst = 1'b0;
          end else if ((k == 1) && rst_at) begin
            rst = 1'b1;
            in_reset = 1'b1;
            ncyc = 2;
            p_if = 1'b0; p_mem = 1'b0;
            bus.if_req = 1'b0; bus.mem_req = 1'b0;
            last_data = 1'b0;
            e_addr = 8'd0; e_wdata = 32'd0; e_ifd = 32'd0; e_memd = 32'd0;
          end else if ((k == 1) && (lat_l > 0)) begin
            // winner's address/data are free to move once granted
            if (win_d) begin
              bus.mem_addr = 8'($urandom); bus.mem_wdata = $urandom; bus.mem_we = 1'($urandom);
              if ($urandom_range(0, 3) == 0) begin p_mem = 1'b0; bus.mem_req = 1'b0; end
            end else begin
              bus.if_addr = 8'($urandom);
              if ($urandom_range(0, 3) == 0) begin p_if = 1'b0; bus.if_req = 1'b0; end
            end
          end else begin
            if (k == lat_l) begin
              if (win_d) begin p_mem = 1'b0; bus.mem_req = 1'b0; end
              else       begin p_if  = 1'b0; bus.if_req  = 1'b0; end
            end
          end
        end
      end
      done = 1'b1;
    end
  end

  initial begin
    for (int c = 0; c < 20000; c++) begin
      @(posedge clock);
      if (g_cfg[0].done && g_cfg[1].done) break;
    end
    chk("finish", 32'(g_cfg[0].done & g_cfg[1].done), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 8, the RAM word-address width.
REQ-002 The module SHALL have parameter RAM_LAT, default 1, the RAM read latency in clock edges; legal range 1..4; any other value SHALL stop elaboration.
REQ-003 Ports SHALL be:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  instruction-fetch read request
- if_addr  in  ADDR_W  fetch address
- mem_req  in  1  MEM-stage load/store request
- mem_we  in  1  1 = store, 0 = load
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  32  store data
- ram_q  in  32  RAM read data
- ram_addr  out  ADDR_W  RAM address, registered
- ram_wdata  out  32  RAM write data, registered
- ram_wren  out  1  RAM write enable, registered
- if_valid  out  1  one-cycle fetch-complete pulse
- if_rdata  out  32  fetched word
- mem_valid  out  1  one-cycle load/store-complete pulse
- mem_rdata  out  32  loaded word (feeds qram of MEM/WB)
- stall_if  out  1  freeze IF stage
- stall_mem  out  1  freeze pipeline at MEM
- busy  out  1  state != IDLE

Function
REQ-004 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-005 In IDLE, the request lines SHALL be sampled at each rising edge; with no request, the FSM SHALL stay in IDLE.
REQ-006 With one request pending in IDLE, that request SHALL be granted.
REQ-007 With both requests pending in IDLE, the requester not granted last SHALL be granted (last_grant flag); after reset, data SHALL win the first tie.
REQ-008 On the grant edge, the module SHALL register the granted address into ram_addr.
REQ-009 On a data grant, the module SHALL also register ram_wdata <= mem_wdata and ram_wren <= mem_we.
REQ-010 On the grant edge, the module SHALL update last_grant, load cnt <= (store ? 1 : RAM_LAT), and go to WAIT.
REQ-011 ram_wren SHALL be high for exactly one cycle per store.
REQ-012 ram_wren SHALL be 0 in all other cycles.
REQ-013 ram_addr and ram_wdata SHALL hold their last values outside grants.
REQ-014 In WAIT, cnt SHALL decrement every edge.
REQ-015 At the WAIT edge where cnt == 1, the FSM SHALL go to RESP.
REQ-016 For a load or fetch, that same edge SHALL capture ram_q into mem_rdata or if_rdata.
REQ-017 A read SHALL therefore sample ram_q exactly RAM_LAT edges after the grant edge.
REQ-018 In RESP, exactly one of if_valid / mem_valid SHALL be high, matching the granted requester.
REQ-019 On the edge leaving RESP, the FSM SHALL return to IDLE.
REQ-020 Requests present during RESP SHALL NOT be granted; they are the next instruction's requests and are sampled from IDLE.
REQ-021 Grant-to-valid latency SHALL be RAM_LAT+1 cycles for reads and 2 cycles for stores; minimum issue interval SHALL be latency+1 cycles.
REQ-022 if_rdata and mem_rdata SHALL hold their value until the next capture.
REQ-023 A store SHALL leave mem_rdata unchanged.
REQ-024 stall_if SHALL be combinational: if_req & ~if_valid.
REQ-025 stall_mem SHALL be combinational: mem_req & ~mem_valid.
REQ-026 A requester deasserting req during WAIT SHALL NOT abort the transaction; the store still writes, and valid still pulses.
REQ-027 Address/data changes after the grant edge SHALL be ignored.
REQ-028 busy SHALL be high in WAIT and RESP.

Reset
REQ-029 When reset is high at an edge, the module SHALL set state = IDLE, cnt = 0, last_grant = IF, ram_wren = 0, ram_addr = 0, ram_wdata = 0, if_rdata = 0, mem_rdata = 0, if_valid = 0, mem_valid = 0.
REQ-030 Reset SHALL take priority over all other activity.
REQ-031 Reset mid-transaction SHALL discard the transaction with no valid pulse.
REQ-032 A store whose wren cycle coincides with the reset edge SHALL still see wren already registered high in that cycle; the following cycle SHALL show wren = 0.
REQ-033 stall outputs SHALL follow REQ-024/REQ-025 during reset.

Verification
REQ-034 Load, RAM_LAT=1: mem_req=1, mem_we=0, mem_addr=0x10, RAM[0x10]=0xDEADBEEF -> ram_addr=0x10 after grant edge; mem_valid pulses in the 2nd cycle after grant; mem_rdata=0xDEADBEEF; stall_mem high until then.
REQ-035 Store: mem_we=1, addr 0x22, wdata 0x12345678 -> ram_wren high one cycle with ram_addr=0x22 and ram_wdata=0x12345678; mem_valid 2 cycles after grant; mem_rdata unchanged.
REQ-036 Contention: if_req and mem_req both held high from reset release -> grant order data, IF, data, IF; no requester waits more than one other transaction.
REQ-037 RAM_LAT=3 fetch: if_addr=0x04, RAM=0x20080005 -> if_valid 4 cycles after grant; if_rdata=0x20080005; busy high for 4 cycles.
REQ-038 Reset asserted in WAIT of a load -> next cycle IDLE, no mem_valid, outputs at reset values; a new request afterwards completes normally.
REQ-039 Request held high through RESP -> no grant on the RESP edge; re-sampled in IDLE one cycle later.
